online_integer_radix2_collector: RTL and testbench

- Radix-2 online-to-integer converter. Sits directly downstream of the radix-2 integer-to-online interface and of the online arithmetic stages.
- Consumes a most-significant-digit-first signed-digit stream on the read-bus side. Rebuilds the two's-complement integer by on-the-fly conversion (Q/QM register pair, no carry-propagate add).
- Presents the result on a valid/ready result port for the host/HLS side.

---
 rtl/online_pkg.sv | 22 ++
 rtl/online_digit_decode_radix2.sv | 25 ++
 rtl/online_integer_radix2_collector.sv | 114 +++++++++++
 tb/tb_online_integer_radix2_collector.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/online_pkg.sv
// Shared definitions for the radix-2 online digit consumers.
package online_pkg;

  // Signed-digit encoding: one-hot plus/minus, 00 and 11 both mean zero.
  localparam logic [1:0] SD_PLUS  = 2'b10;
  localparam logic [1:0] SD_MINUS = 2'b01;

  // Borrow-save encoding: bit 0 is the digit present, bit 1 its sign.
  localparam logic [1:0] BS_PLUS  = 2'b01;
  localparam logic [1:0] BS_MINUS = 2'b11;

  // Decoded digit value, -1 / 0 / +1.
  typedef logic signed [1:0] digit_t;

  // Collector frame state.
  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

endpackage

// File: rtl/online_digit_decode_radix2.sv
// Maps a 2-bit radix-2 online digit code to a plus/minus flag pair.
module online_digit_decode_radix2
  import online_pkg::*;
#(
  parameter string ENCODING_MODE = "signed-digit"
) (
  input  logic [1:0] code_i,
  output logic       plus_o,
  output logic       minus_o
);

  // Decode by encoding mode; an unknown mode reads every digit as zero.
  always_comb begin
    plus_o  = 1'b0;
    minus_o = 1'b0;
    if (ENCODING_MODE == "signed-digit") begin
      plus_o  = (code_i == SD_PLUS);
      minus_o = (code_i == SD_MINUS);
    end else if (ENCODING_MODE == "borrow-save") begin
      plus_o  = (code_i == BS_PLUS);
      minus_o = (code_i == BS_MINUS);
    end
  end

endmodule

// File: rtl/online_integer_radix2_collector.sv
// Radix-2 online-to-integer converter: MSD-first digit stream in, two's
// complement integer out on a valid/ready port, via Q/QM on-the-fly conversion.
module online_integer_radix2_collector
  import online_pkg::*;
#(
  parameter string       ENCODING_MODE = "signed-digit",
  parameter int unsigned MAX_DIGITS    = 16,
  parameter int unsigned CNT_WIDTH     = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_mbus_rdata,
  input  logic                  i_mbus_rvalid,
  input  logic                  i_mbus_rlast,
  output logic [MAX_DIGITS:0]   o_int_data,
  output logic [CNT_WIDTH-1:0]  o_int_digits,
  output logic                  o_int_ovf,
  output logic                  o_int_valid,
  input  logic                  i_int_ready,
  output logic                  o_err_overrun,
  output logic                  o_busy
);

  localparam int unsigned          W       = MAX_DIGITS + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_DIGITS);

  state_e                state_q, state_d;
  logic [W-1:0]          q_q, q_d;
  logic [W-1:0]          qm_q, qm_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;
  logic                  dig_plus, dig_minus;

  online_digit_decode_radix2 #(
    .ENCODING_MODE(ENCODING_MODE)
  ) u_decode (
    .code_i (i_mbus_rdata),
    .plus_o (dig_plus),
    .minus_o(dig_minus)
  );

  // Next-state: digit accumulation, frame end, result handshake, overrun flag.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = 1'b0;
    case (state_q)
      // IDLE holds freshly initialised Q/QM/count, so a first digit is
      // accepted by exactly the same path as any later one.
      IDLE, ACCUM: begin
        if (i_mbus_rvalid) begin
          if (dig_plus) begin
            q_d  = {q_q[W-2:0], 1'b1};
            qm_d = {q_q[W-2:0], 1'b0};
          end else if (dig_minus) begin
            q_d  = {qm_q[W-2:0], 1'b1};
            qm_d = {qm_q[W-2:0], 1'b0};
          end else begin
            q_d  = {q_q[W-2:0], 1'b0};
            qm_d = {qm_q[W-2:0], 1'b1};
          end
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
          if (cnt_d > CNT_MAX) ovf_d = 1'b1;
          state_d = ACCUM;
        end
        if (i_mbus_rlast) state_d = DONE;
      end
      DONE: begin
        err_d = i_mbus_rvalid | i_mbus_rlast;
        if (i_int_ready) begin
          q_d     = '0;
          qm_d    = '1;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      qm_q    <= '1;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Result fields are masked outside DONE so partial values never leak out.
  assign o_int_valid   = (state_q == DONE);
  assign o_int_data    = o_int_valid ? q_q : '0;
  assign o_int_digits  = o_int_valid ? cnt_q : '0;
  assign o_int_ovf     = o_int_valid & ovf_q;
  assign o_busy        = (state_q != IDLE);
  assign o_err_overrun = err_q;

endmodule

// File: tb/tb_online_integer_radix2_collector.sv
// Self-checking bench: a signed-digit and a borrow-save collector share the
// same digit stream; each is compared with an arithmetic reference model.
module tb_online_integer_radix2_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rdata;
  logic        rvalid, rlast, ready;

  logic [16:0] data_sd, data_bs;
  logic [4:0]  digits_sd, digits_bs;
  logic        ovf_sd, ovf_bs, valid_sd, valid_bs, err_sd, err_bs, busy_sd, busy_bs;

  int total = 0;
  int bad   = 0;
  logic [1:0] codes[$];

  always #5 clk = ~clk;

  online_integer_radix2_collector dut_sd (
    .i_clk(clk), .i_rst(rst), .i_mbus_rdata(rdata), .i_mbus_rvalid(rvalid),
    .i_mbus_rlast(rlast), .o_int_data(data_sd), .o_int_digits(digits_sd),
    .o_int_ovf(ovf_sd), .o_int_valid(valid_sd), .i_int_ready(ready),
    .o_err_overrun(err_sd), .o_busy(busy_sd)
  );

  online_integer_radix2_collector #(
    .ENCODING_MODE("borrow-save")
  ) dut_bs (
    .i_clk(clk), .i_rst(rst), .i_mbus_rdata(rdata), .i_mbus_rvalid(rvalid),
    .i_mbus_rlast(rlast), .o_int_data(data_bs), .o_int_digits(digits_bs),
    .o_int_ovf(ovf_bs), .o_int_valid(valid_bs), .i_int_ready(ready),
    .o_err_overrun(err_bs), .o_busy(busy_bs)
  );

  // ---------------- reference model ----------------
  function automatic int dec(input logic [1:0] c, input bit bs);
    if (!bs) return (c == 2'b10) ? 1 : (c == 2'b01) ? -1 : 0;
    return (c == 2'b01) ? 1 : (c == 2'b11) ? -1 : 0;
  endfunction

  // Integer value sum d_i*2^(N-i), reduced to 17 bits.
  function automatic logic [16:0] model_val(input bit bs);
    longint v = 0;
    foreach (codes[i]) v = v * 2 + longint'(dec(codes[i], bs));
    return v[16:0];
  endfunction

  function automatic logic [23:0] model_res(input bit bs);
    int n = codes.size();
    logic [4:0] d = (n > 31) ? 5'd31 : 5'(n);
    return {1'b1, model_val(bs), d, (n > 16)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends the queued digits; rlast rides the last digit unless 'alone'.
  task automatic drive_frame(input bit alone);
    for (int i = 0; i < codes.size(); i++) begin
      rvalid = 1'b1;
      rdata  = codes[i];
      rlast  = (i == codes.size() - 1) && !alone;
      total++;
      if ({valid_sd, valid_bs} !== 2'b00) begin
        bad++;
        $display("FAIL early_valid: got %b want 00", {valid_sd, valid_bs});
      end
      step();
    end
    if (alone || codes.size() == 0) begin
      rvalid = 1'b0;
      rlast  = 1'b1;
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rdata  = 2'b00;
  endtask

  task automatic handshake();
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; rdata = 2'b00; rvalid = 1'b0; rlast = 1'b0; ready = 1'b0;
    step(); step();
    rst = 1'b0;
    total++;
    if ({data_sd, digits_sd, ovf_sd, valid_sd, err_sd, busy_sd,
         data_bs, digits_bs, ovf_bs, valid_bs, err_bs, busy_bs} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: sd data=%h dig=%0d v=%b bs data=%h dig=%0d v=%b want all 0",
               data_sd, digits_sd, valid_sd, data_bs, digits_bs, valid_bs);
    end
  endtask

  task automatic test_directed();
    for (int k = 0; k < 7; k++) begin
      bit alone = 1'b0;
      case (k)
        0: codes = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
        1: codes = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
        2: codes = '{2'b10, 2'b01, 2'b10, 2'b01};
        3: codes = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        4: codes = '{2'b01, 2'b11, 2'b11};
        5: begin codes = {}; alone = 1'b1; end
        default: begin codes = '{2'b10, 2'b00}; alone = 1'b1; end
      endcase
      drive_frame(alone);
      total++;
      if ({valid_sd, data_sd, digits_sd, ovf_sd} !== model_res(1'b0)) begin
        bad++;
        $display("FAIL directed%0d_sd: got %h want %h", k,
                 {valid_sd, data_sd, digits_sd, ovf_sd}, model_res(1'b0));
      end
      total++;
      if ({valid_bs, data_bs, digits_bs, ovf_bs} !== model_res(1'b1)) begin
        bad++;
        $display("FAIL directed%0d_bs: got %h want %h", k,
                 {valid_bs, data_bs, digits_bs, ovf_bs}, model_res(1'b1));
      end
      handshake();
      step();
      total++;
      if ({valid_sd, busy_sd, valid_bs, busy_bs} !== 4'b0000) begin
        bad++;
        $display("FAIL directed%0d_release: got %b want 0000", k,
                 {valid_sd, busy_sd, valid_bs, busy_bs});
      end
    end
  endtask

  task automatic test_overrun();
    codes = '{2'b10, 2'b10, 2'b01};
    drive_frame(1'b0);
    for (int c = 0; c < 5; c++) begin
      bit pulse = (c == 1 || c == 3);
      rvalid = pulse;
      rdata  = 2'b01;
      step();
      total++;
      if ({valid_sd, data_sd, digits_sd, ovf_sd, err_sd, err_bs} !== {model_res(1'b0), pulse, pulse}) begin
        bad++;
        $display("FAIL overrun_hold%0d: got %h err=%b%b want %h err=%b", c,
                 {valid_sd, data_sd, digits_sd, ovf_sd}, err_sd, err_bs, model_res(1'b0), pulse);
      end
    end
    rvalid = 1'b1;
    ready  = 1'b1;
    step();
    rvalid = 1'b0;
    ready  = 1'b0;
    total++;
    if ({err_sd, valid_sd} !== 2'b10) begin
      bad++;
      $display("FAIL overrun_handshake: got err,valid=%b want 10", {err_sd, valid_sd});
    end
    step();
    total++;
    if ({err_sd, busy_sd, busy_bs} !== 3'b000) begin
      bad++;
      $display("FAIL overrun_ignored: got err,busy=%b want 000", {err_sd, busy_sd, busy_bs});
    end
    codes = '{2'b10, 2'b00, 2'b10};
    drive_frame(1'b0);
    total++;
    if ({valid_sd, data_sd, digits_sd, ovf_sd} !== model_res(1'b0)) begin
      bad++;
      $display("FAIL overrun_next: got %h want %h",
               {valid_sd, data_sd, digits_sd, ovf_sd}, model_res(1'b0));
    end
    handshake();
  endtask

  task automatic test_overflow();
    foreach (codes[i]) ; // keep queue state irrelevant
    for (int k = 0; k < 2; k++) begin
      codes = {};
      for (int i = 0; i < (k == 0 ? 17 : 40); i++)
        codes.push_back(k == 0 ? 2'b10 : 2'($urandom_range(0, 3)));
      drive_frame(1'b0);
      total++;
      if ({valid_sd, data_sd, digits_sd, ovf_sd} !== model_res(1'b0)) begin
        bad++;
        $display("FAIL overflow%0d_sd: got %h want %h", k,
                 {valid_sd, data_sd, digits_sd, ovf_sd}, model_res(1'b0));
      end
      total++;
      if ({valid_bs, data_bs, digits_bs, ovf_bs} !== model_res(1'b1)) begin
        bad++;
        $display("FAIL overflow%0d_bs: got %h want %h", k,
                 {valid_bs, data_bs, digits_bs, ovf_bs}, model_res(1'b1));
      end
      handshake();
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1;
      rdata  = 2'b10;
      step();
    end
    rvalid = 1'b0;
    rst    = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({data_sd, digits_sd, ovf_sd, valid_sd, err_sd, busy_sd,
         data_bs, digits_bs, ovf_bs, valid_bs, err_bs, busy_bs} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: sd v=%b busy=%b bs v=%b busy=%b want 0",
               valid_sd, busy_sd, valid_bs, busy_bs);
    end
    codes = '{2'b10, 2'b00};
    drive_frame(1'b0);
    total++;
    if ({valid_sd, data_sd, digits_sd, ovf_sd} !== model_res(1'b0)) begin
      bad++;
      $display("FAIL midreset_frame: got %h want %h",
               {valid_sd, data_sd, digits_sd, ovf_sd}, model_res(1'b0));
    end
    handshake();
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int n = $urandom_range(0, 20);
      bit alone;
      codes = {};
      for (int i = 0; i < n; i++) codes.push_back(2'($urandom_range(0, 3)));
      alone = (n == 0) || ($urandom_range(0, 1) == 1);
      drive_frame(alone);
      repeat ($urandom_range(0, 3)) step();
      total++;
      if ({valid_sd, data_sd, digits_sd, ovf_sd} !== model_res(1'b0)) begin
        bad++;
        $display("FAIL random%0d_sd: got %h want %h", f,
                 {valid_sd, data_sd, digits_sd, ovf_sd}, model_res(1'b0));
      end
      total++;
      if ({valid_bs, data_bs, digits_bs, ovf_bs} !== model_res(1'b1)) begin
        bad++;
        $display("FAIL random%0d_bs: got %h want %h", f,
                 {valid_bs, data_bs, digits_bs, ovf_bs}, model_res(1'b1));
      end
      handshake();
      total++;
      if ({valid_sd, valid_bs, err_sd, err_bs} !== 4'b0000) begin
        bad++;
        $display("FAIL random%0d_release: got %b want 0000", f,
                 {valid_sd, valid_bs, err_sd, err_bs});
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overrun();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule
